// File: rtl/ddr_align_monitor.sv
// ddr_align_monitor
// Checks deserialized read words against a rotated training pattern over fixed
// windows. Publishes {word misaligned, sampling error} to the read-path phase
// controller and honours its flush (reset_datapath) and freeze (stop) strobes.
// Pipeline: S1 capture -> S2 rotation match -> S3 accumulate/publish.

module ddr_align_monitor #(
   parameter int                    DATA_WIDTH    = 8,
   parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 8'h5A,
   parameter int                    WINDOW        = 16,
   parameter int                    RW            = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_valid,
   input  logic                  reset_datapath,
   input  logic                  stop,
   output logic [1:0]            align_status,
   output logic [RW-1:0]         rot_idx,
   output logic                  window_done
);

   localparam int            CW       = $clog2(WINDOW);
   localparam logic [CW-1:0] LAST_CNT = CW'(WINDOW - 1);

   // Rotate a word left by r bit positions.
   function automatic logic [DATA_WIDTH-1:0] rotl(input logic [DATA_WIDTH-1:0] w,
                                                  input int r);
      logic [DATA_WIDTH-1:0] res;
      res = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         res[(i + r) % DATA_WIDTH] = w[i];
      end
      return res;
   endfunction

   // Pipeline state
   logic [DATA_WIDTH-1:0] s1_word_r;
   logic                  v1_r;
   logic [DATA_WIDTH-1:0] match_r;
   logic                  v2_r;

   // Window state
   logic [CW-1:0]         cnt_r;
   logic [RW-1:0]         rot_ref_r;
   logic                  bit_err_acc_r;
   logic                  word_err_acc_r;

   // Published outputs
   logic [1:0]            align_status_r;
   logic [RW-1:0]         rot_idx_r;
   logic                  window_done_r;

   // Combinational intermediates
   logic [DATA_WIDTH-1:0] match_s;
   logic                  hit_s;
   logic [RW-1:0]         rot_s;
   logic                  first_s;
   logic [RW-1:0]         ref_s;
   logic                  bit_err_s;
   logic                  word_err_s;
   logic                  last_s;

   // Compare the S1 word against every rotation of the training pattern.
   always_comb begin
      match_s = '0;
      for (int r = 0; r < DATA_WIDTH; r++) begin
         match_s[r] = (s1_word_r == rotl(TRAIN_PATTERN, r));
      end
   end

   // Pick the lowest matching rotation; a degenerate pattern resolves to 0.
   always_comb begin
      hit_s = 1'b0;
      rot_s = '0;
      for (int r = DATA_WIDTH - 1; r >= 0; r--) begin
         rot_s = match_r[r] ? RW'(r) : rot_s;
         hit_s = hit_s | match_r[r];
      end
   end

   // Classify the S2 word and fold it into the window verdict.
   always_comb begin
      first_s    = (cnt_r == '0);
      ref_s      = first_s ? rot_s : rot_ref_r;
      bit_err_s  = bit_err_acc_r | ~hit_s | (~first_s & (rot_s != rot_ref_r));
      word_err_s = word_err_acc_r | (ref_s != '0);
      last_s     = v2_r & (cnt_r == LAST_CNT);
   end

   // S1/S2 pipeline registers; stop blocks new capture, a flush empties the pipe.
   always_ff @(posedge clk) begin
      if (reset || reset_datapath) begin
         s1_word_r <= '0;
         v1_r      <= 1'b0;
         match_r   <= '0;
         v2_r      <= 1'b0;
      end else begin
         s1_word_r <= data_in;
         v1_r      <= data_valid & ~stop;
         match_r   <= match_s;
         v2_r      <= v1_r;
      end
   end

   // S3 window accumulation and publish; the final word's verdict goes straight out.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r          <= '0;
         rot_ref_r      <= '0;
         bit_err_acc_r  <= 1'b0;
         word_err_acc_r <= 1'b0;
         align_status_r <= 2'b11;
         rot_idx_r      <= '0;
         window_done_r  <= 1'b0;
      end else if (reset_datapath) begin
         cnt_r          <= '0;
         rot_ref_r      <= '0;
         bit_err_acc_r  <= 1'b0;
         word_err_acc_r <= 1'b0;
         align_status_r <= 2'b11;
         window_done_r  <= 1'b0;
      end else if (last_s) begin
         cnt_r          <= '0;
         rot_ref_r      <= '0;
         bit_err_acc_r  <= 1'b0;
         word_err_acc_r <= 1'b0;
         align_status_r <= {word_err_s, bit_err_s};
         rot_idx_r      <= ref_s;
         window_done_r  <= 1'b1;
      end else if (v2_r) begin
         cnt_r          <= cnt_r + CW'(1);
         rot_ref_r      <= ref_s;
         bit_err_acc_r  <= bit_err_s;
         word_err_acc_r <= word_err_s;
         window_done_r  <= 1'b0;
      end else begin
         window_done_r  <= 1'b0;
      end
   end

   assign align_status = align_status_r;
   assign rot_idx      = rot_idx_r;
   assign window_done  = window_done_r;

endmodule
